// File: rtl/pix_fifo.sv
`default_nettype none
// pix_fifo: synchronous RGB332 pixel FIFO feeding the VGA controller.
// Empty reads return BLANK_PIX and latch a sticky underflow flag so the display never stalls.
module pix_fifo #(
   parameter int         DEPTH_LOG2   = 4,
   parameter int         AFULL_THRESH = 12,
   parameter logic [7:0] BLANK_PIX    = 8'h00
) (
   input  logic                  CLKIN_IN,
   input  logic                  RST_IN,
   input  logic                  WR_EN,
   input  logic [7:0]            WR_DATA,
   output logic                  FULL,
   output logic                  AFULL,
   output logic [DEPTH_LOG2:0]   LEVEL,
   input  logic                  RD_EN,
   output logic [7:0]            PIX_DATA,
   output logic                  PIX_VALID,
   input  logic                  FLUSH,
   output logic                  UNDERFLOW,
   input  logic                  CLR_UFLOW
);

   localparam int                DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] PTR_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2:0] AFULL_LVL = AFULL_THRESH[DEPTH_LOG2:0];

   logic [7:0]              mem [DEPTH];
   logic [DEPTH_LOG2:0]     wr_ptr;
   logic [DEPTH_LOG2:0]     rd_ptr;
   logic                    empty;
   logic                    wr_ok;
   logic                    rd_ok;
   logic                    uflow_set;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign empty     = (wr_ptr == rd_ptr);
   assign FULL      = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                      (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
   assign LEVEL     = wr_ptr - rd_ptr;
   assign AFULL     = (LEVEL >= AFULL_LVL);

   assign wr_ok     = WR_EN && !FULL && !FLUSH;
   assign rd_ok     = RD_EN && !empty && !FLUSH;
   assign uflow_set = RD_EN && empty && !FLUSH;

   always_ff @(posedge CLKIN_IN) begin
      if (wr_ok) begin
         mem[wr_ptr[DEPTH_LOG2-1:0]] <= WR_DATA;
      end
   end

   always_ff @(posedge CLKIN_IN or negedge RST_IN) begin
      if (!RST_IN) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         PIX_DATA  <= BLANK_PIX;
         PIX_VALID <= 1'b0;
         UNDERFLOW <= 1'b0;
      end else begin
         if (FLUSH) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            PIX_DATA  <= BLANK_PIX;
            PIX_VALID <= 1'b0;
         end else begin
            if (wr_ok) begin
               wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
               PIX_DATA  <= mem[rd_ptr[DEPTH_LOG2-1:0]];
               PIX_VALID <= 1'b1;
               rd_ptr    <= rd_ptr + PTR_ONE;
            end else if (RD_EN) begin
               PIX_DATA  <= BLANK_PIX;
               PIX_VALID <= 1'b0;
            end else begin
               PIX_VALID <= 1'b0;
            end
         end
         // A new underflow outranks a same-cycle clear.
         if (uflow_set) begin
            UNDERFLOW <= 1'b1;
         end else if (CLR_UFLOW) begin
            UNDERFLOW <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire
